// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state type, constants and helpers for the alarm ring controller
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;

  function automatic int cnt_width(input int ring_secs, input int snooze_secs);
    return $clog2((ring_secs > snooze_secs ? ring_secs : snooze_secs) + 1);
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lowest_idx = 3'(i);
  endfunction

endpackage

// File: rtl/alarm_match.sv
// alarm_match: per-channel hour/minute comparator with lowest-index winner
module alarm_match
  import alarm_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
)(
  input  logic [7:0]     hour,
  input  logic [7:0]     minute,
  input  logic [8*N-1:0] alm_hour,
  input  logic [8*N-1:0] alm_min,
  input  logic [N-1:0]   alm_en,
  output logic           any_match,
  output logic [IDW-1:0] win_id,
  output logic [N-1:0]   match
);

  // an enabled channel matches when both its hour and minute equal the current time
  always_comb
    for (int i = 0; i < N; i++)
      match[i] = alm_en[i] && hour == alm_hour[8*i +: 8] && minute == alm_min[8*i +: 8];

  assign any_match = |match;
  assign win_id    = IDW'(lowest_idx(8'(match)));

endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: multi-channel alarm with ring timeout, snooze, missed record and hourly chime
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int N_ALARMS   = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int CHIME_SECS = 2,
  localparam int IDW = N_ALARMS > 1 ? $clog2(N_ALARMS) : 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sec_tick,
  input  logic [7:0]            hour,
  input  logic [7:0]            minute,
  input  logic [7:0]            second,
  input  logic [8*N_ALARMS-1:0] alm_hour,
  input  logic [8*N_ALARMS-1:0] alm_min,
  input  logic [N_ALARMS-1:0]   alm_en,
  input  logic                  chime_en,
  input  logic                  ack,
  input  logic                  snooze,
  input  logic                  missed_clr,
  output logic                  alert,
  output logic                  chime,
  output logic [IDW-1:0]        ring_id,
  output logic                  snoozing,
  output logic [1:0]            snooze_cnt,
  output logic [N_ALARMS-1:0]   missed
);

  localparam int CW = cnt_width(RING_SECS, SNOOZE_MIN * 60);
  localparam int HW = $clog2(CHIME_SECS + 1);
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_MIN * 60);
  localparam logic [HW-1:0] CHIME_LOAD  = HW'(CHIME_SECS);

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [HW-1:0]         chime_left, chime_left_n;
  logic [1:0]            scnt_n;
  logic [IDW-1:0]        id_n, win_id;
  logic [N_ALARMS-1:0]   match, miss_set, active;
  logic                  any_match, eval, chime_start, chime_n;

  alarm_match #(.N(N_ALARMS), .IDW(IDW)) u_match (
    .hour      (hour),
    .minute    (minute),
    .alm_hour  (alm_hour),
    .alm_min   (alm_min),
    .alm_en    (alm_en),
    .any_match (any_match),
    .win_id    (win_id),
    .match     (match)
  );

  assign eval   = sec_tick && second == BCD_ZERO;
  assign active = N_ALARMS'(1) << (state == IDLE ? win_id : ring_id);

  // next state, shared ring/snooze counter, missed updates and chime control
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    scnt_n   = snooze_cnt;
    id_n     = ring_id;
    miss_set = eval ? match & ~active : '0;
    case (state)
      IDLE:
        if (eval && any_match) begin
          state_n = RING;
          id_n    = win_id;
          cnt_n   = '0;
          scnt_n  = '0;
        end
      RING:
        if (ack || (snooze && int'(snooze_cnt) >= MAX_SNOOZE)) state_n = IDLE;
        else if (snooze) begin
          state_n = SNOOZE;
          cnt_n   = SNOOZE_LOAD;
          scnt_n  = snooze_cnt + 2'(snooze_cnt != 2'd3);
        end
        else if (!alm_en[ring_id]) state_n = IDLE;
        else if (sec_tick && cnt == RING_LAST) begin
          state_n  = IDLE;
          miss_set = miss_set | active;
        end
        else if (sec_tick) cnt_n = cnt + 1'b1;
      SNOOZE:
        if (ack) state_n = IDLE;
        else if (sec_tick && cnt < CW'(2)) begin
          state_n = RING;
          cnt_n   = '0;
        end
        else if (sec_tick) cnt_n = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
    chime_start  = chime_en && sec_tick && minute == BCD_ZERO && second == BCD_ZERO && state_n != RING;
    chime_n      = chime_en && state_n != RING && (chime_start || (chime && !(sec_tick && chime_left == HW'(1))));
    chime_left_n = chime_start ? CHIME_LOAD : (chime && sec_tick) ? chime_left - 1'b1 : chime_left;
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      chime_left <= '0;
      alert      <= 1'b0;
      chime      <= 1'b0;
      ring_id    <= '0;
      snoozing   <= 1'b0;
      snooze_cnt <= '0;
      missed     <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      chime_left <= chime_left_n;
      alert      <= state_n == RING;
      chime      <= chime_n;
      ring_id    <= id_n;
      snoozing   <= state_n == SNOOZE;
      snooze_cnt <= scnt_n;
      missed     <= (missed_clr ? '0 : missed) | miss_set;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Multi-channel alarm and hourly-chime controller for the digital clock datapath.
- Sits after the timekeeping counters (BCD hour/minute/second) and drives the buzzer/LED alert logic.
- Adds ring timeout, snooze with a count limit, acknowledge, a missed-alarm record and a separate hourly chime.
- Fully registered outputs, single clock domain.

Parameters:
- N_ALARMS, 4, number of independent alarm channels (1..8).
- RING_SECS, 60, seconds an alarm rings before auto-timeout.
- SNOOZE_MIN, 5, snooze length in minutes.
- MAX_SNOOZE, 3, snoozes allowed per alarm event; after that, snooze acts as ack.
- CHIME_SECS, 2, seconds the hourly chime output stays high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sec_tick  in  1  one-cycle strobe, once per second, coincident with time update.
- hour  in  8  current hour, BCD 00-23.
- minute  in  8  current minute, BCD 00-59.
- second  in  8  current second, BCD 00-59.
- alm_hour  in  8*N_ALARMS  alarm hours, channel i at [8i+7:8i].
- alm_min  in  8*N_ALARMS  alarm minutes, same packing.
- alm_en  in  N_ALARMS  per-channel enable.
- chime_en  in  1  hourly chime enable.
- ack  in  1  stop-ringing pulse, one cycle.
- snooze  in  1  snooze request pulse, one cycle.
- missed_clr  in  1  clears the missed register.
- alert  out  1  alarm ringing.
- chime  out  1  hourly chime active.
- ring_id  out  IDW  active channel index, IDW = max(1,$clog2(N_ALARMS)).
- snoozing  out  1  snooze in progress.
- snooze_cnt  out  2  snoozes used in the current event (saturates at 3).
- missed  out  N_ALARMS  sticky per-channel flag, set on timeout or ignored trigger.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM in IDLE, all counters 0.
- Evaluation occurs only on a sec_tick cycle with second==8'h00. match[i] = alm_en[i] & hour==alm_hour[i] & minute==alm_min[i].
- Lowest matching index wins. Outputs update on the clock edge after the evaluating tick (1-cycle latency).
- FSM states IDLE, RING, SNOOZE:
  - IDLE, any match: RING; ring_id=winner; sec counter=0; snooze_cnt=0; alert=1.
  - RING, ack: IDLE; alert=0.
  - RING, snooze with snooze_cnt<MAX_SNOOZE: SNOOZE; alert=0; snoozing=1; snooze_cnt+1; countdown loaded with SNOOZE_MIN*60.
  - RING, snooze with snooze_cnt>=MAX_SNOOZE: treated as ack.
  - RING, sec_tick with elapsed==RING_SECS-1: IDLE; missed[ring_id] set.
  - RING, alm_en[ring_id] deasserted: IDLE next cycle; missed is not set.
  - SNOOZE, sec_tick: countdown decrements. When it reaches 0: RING, ring counter restarted, snooze_cnt kept.
  - SNOOZE, ack: IDLE; snoozing=0.
- Ack and snooze in the same cycle: ack wins. Ack on a timeout tick: IDLE with missed not set.
- Matches on other channels while in RING or SNOOZE are not queued. Their missed bits are set.
- missed_clr clears all missed bits. If a set and missed_clr happen in the same cycle, the set wins.
- Chime:
  - Starts when chime_en=1 on a sec_tick with minute==8'h00 and second==8'h00, and state is IDLE or the FSM is not entering RING that cycle.
  - Holds for CHIME_SECS ticks, then clears.
  - Forced to 0 whenever alert=1. An alarm at hh:00 suppresses that hour's chime.
  - Deasserting chime_en clears chime next cycle.
- Counter width: $clog2(max(RING_SECS, SNOOZE_MIN*60)+1). No wrap: the counter is compared, never overflowed.
- Inputs are not range-checked. Invalid BCD simply never matches.

Decomposition:
- Package alarm_pkg holds:
  - State enum (IDLE/RING/SNOOZE).
  - BCD_ZERO constant.
  - A function computing the counter width.
  - A lowest-index priority-encoder function.
- Sub-module alarm_match: combinational N-channel comparator plus priority encoder, outputs any_match, win_id and the match vector.
- FSM, counters and chime logic stay in the top level.

Test Plan:
- alm_en=0001, alarm 07:30. Tick at 07:30:00 → alert=1, ring_id=0 one cycle after the tick. ack 5 s later → alert=0 next cycle, missed=0.
- Channels 1 and 2 both set to 12:00 → ring_id=1, missed[2]=1, chime stays 0 despite minute==00.
- Alarm rings with no ack, RING_SECS=60 → alert drops after the 60th tick, missed[ch]=1. missed_clr → 0.
- snooze pressed 3 times, each snooze expiring after 300 ticks and re-ringing (snooze_cnt 1,2,3). 4th snooze → IDLE as ack, snoozing=0.
- chime_en=1, no alarms, time 09:59:59→10:00:00 → chime=1 for exactly 2 ticks. Same stimulus with chime_en=0 → chime stays 0.
- rst_n pulled low mid-SNOOZE (asynchronously, between edges) → all outputs 0 immediately. After release, the next matching minute rings with snooze_cnt=0.
